// File: rtl/arb_pkg.sv
// Shared arbiter types: FSM state encoding and a constant-foldable clog2.
// No logic, no latency; no flow control of its own.
// Imported by the interface, the selector and the arbiter top.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/param_priority_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
// Pure wiring, zero latency.
// The grant is held until ack; there are no other stalls.
interface param_priority_arbiter_if #(
  parameter int N = 8
) ();
  import arb_pkg::*;

  localparam int W = clog2(N);

  logic [N-1:0] req;
  logic         ack;
  logic         gnt_valid;
  logic [W-1:0] gnt_idx;
  logic [N-1:0] gnt_onehot;

  modport master (
    output req,
    output ack,
    input  gnt_valid,
    input  gnt_idx,
    input  gnt_onehot
  );

  modport slave (
    input  req,
    input  ack,
    output gnt_valid,
    output gnt_idx,
    output gnt_onehot
  );

endinterface

// File: rtl/prio_select.sv
// Combinational winner pick: fixed highest-index, or round-robin below pointer k.
// Zero latency.
// No flow control; the caller samples the result only when it can load a grant.
module prio_select
  import arb_pkg::*;
#(
  parameter  int N       = 8,
  parameter  int RR_MODE = 0,
  localparam int W       = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] k,
  output logic [W-1:0] winner,
  output logic         any_req
);

  logic         found_lo;
  logic [W-1:0] lo_idx;
  logic [W-1:0] hi_idx;

  // Indices below k outrank k and above; within each group, higher index wins.
  always_comb begin
    any_req  = 1'b0;
    found_lo = 1'b0;
    lo_idx   = '0;
    hi_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        any_req = 1'b1;
        if ((RR_MODE != 0) && (i < int'(k))) begin
          found_lo = 1'b1;
          lo_idx   = W'(i);
        end else begin
          hi_idx = W'(i);
        end
      end
    end
    winner = found_lo ? lo_idx : hi_idx;
  end

endmodule

// File: rtl/param_priority_arbiter.sv
// N-way fixed or round-robin priority arbiter with registered grant outputs.
// One cycle from request sample to gnt_valid; one idle cycle between grants.
// A grant is held stable until ack; requests are not sampled while granting.
module param_priority_arbiter
  import arb_pkg::*;
#(
  parameter int N       = 8,
  parameter int RR_MODE = 0
) (
  input logic clk,
  input logic rst,
  param_priority_arbiter_if.slave bus
);

  localparam int W = clog2(N);

  arb_state_e   state_q;
  arb_state_e   state_d;
  logic         load_grant;
  logic         any_req;
  logic [W-1:0] win_idx;
  logic [W-1:0] rr_ptr_q;

  prio_select #(
    .N       (N),
    .RR_MODE (RR_MODE)
  ) u_sel (
    .req     (bus.req),
    .k       (rr_ptr_q),
    .winner  (win_idx),
    .any_req (any_req)
  );

  always_comb begin
    state_d    = state_q;
    load_grant = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d    = GRANT;
          load_grant = 1'b1;
        end
      end
      GRANT: begin
        if (bus.ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // gnt_idx is left untouched on ack so it keeps its last value while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      bus.gnt_valid  <= 1'b0;
      bus.gnt_idx    <= '0;
      bus.gnt_onehot <= '0;
      rr_ptr_q       <= '0;
    end else begin
      state_q <= state_d;
      if (load_grant) begin
        bus.gnt_valid  <= 1'b1;
        bus.gnt_idx    <= win_idx;
        bus.gnt_onehot <= N'(1) << win_idx;
      end else if ((state_q == GRANT) && bus.ack) begin
        bus.gnt_valid  <= 1'b0;
        bus.gnt_onehot <= '0;
        rr_ptr_q       <= bus.gnt_idx;
      end
    end
  end

endmodule

// File: tb/tb_param_priority_arbiter.sv
// Directed bench: N=8 fixed, N=8 round-robin and an N=5 smoke instance.
module tb_param_priority_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  param_priority_arbiter_if #(.N(8)) if_f ();
  param_priority_arbiter_if #(.N(8)) if_r ();
  param_priority_arbiter_if #(.N(5)) if_s ();

  param_priority_arbiter #(.N(8), .RR_MODE(0)) u_fix (.clk(clk), .rst(rst), .bus(if_f));
  param_priority_arbiter #(.N(8), .RR_MODE(1)) u_rr  (.clk(clk), .rst(rst), .bus(if_r));
  param_priority_arbiter #(.N(5), .RR_MODE(0)) u_n5  (.clk(clk), .rst(rst), .bus(if_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    if_f.req = '0; if_f.ack = 1'b0;
    if_r.req = '0; if_r.ack = 1'b0;
    if_s.req = '0; if_s.ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state on every instance.
    check("rst_fix_valid", 64'(if_f.gnt_valid), 64'd0);
    check("rst_fix_idx", 64'(if_f.gnt_idx), 64'd0);
    check("rst_fix_onehot", 64'(if_f.gnt_onehot), 64'd0);
    check("rst_rr_valid", 64'(if_r.gnt_valid), 64'd0);
    check("rst_n5_valid", 64'(if_s.gnt_valid), 64'd0);

    // Idle with no requests; ack in idle must be ignored.
    if_f.ack = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("idle_valid", 64'(if_f.gnt_valid), 64'd0);
      check("idle_onehot", 64'(if_f.gnt_onehot), 64'd0);
    end
    if_f.ack = 1'b0;

    // Fixed priority: highest set index wins, grant held without ack.
    if_f.req = 8'b0010_0110;
    tick();
    check("fix_valid", 64'(if_f.gnt_valid), 64'd1);
    check("fix_idx", 64'(if_f.gnt_idx), 64'd5);
    check("fix_onehot", 64'(if_f.gnt_onehot), 64'h20);
    if_f.req = 8'h81;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("fix_hold_valid", 64'(if_f.gnt_valid), 64'd1);
      check("fix_hold_idx", 64'(if_f.gnt_idx), 64'd5);
    end
    if_f.ack = 1'b1;
    if_f.req = 8'h00;
    tick();
    if_f.ack = 1'b0;
    check("fix_ack_valid", 64'(if_f.gnt_valid), 64'd0);
    check("fix_ack_onehot", 64'(if_f.gnt_onehot), 64'd0);
    check("fix_ack_idx_kept", 64'(if_f.gnt_idx), 64'd5);
    // Fixed mode ignores history: 7 still beats 0 after serving 7.
    if_f.req = 8'h81;
    tick();
    check("fix_again_idx", 64'(if_f.gnt_idx), 64'd7);

    // Round-robin alternation between two requesters.
    if_r.req = 8'h81;
    for (int g = 0; g < 4; g++) begin
      tick();
      check("rr_alt_valid", 64'(if_r.gnt_valid), 64'd1);
      check("rr_alt_idx", 64'(if_r.gnt_idx), (g % 2 == 0) ? 64'd7 : 64'd0);
      if_r.ack = 1'b1;
      tick();
      if_r.ack = 1'b0;
      check("rr_alt_gap", 64'(if_r.gnt_valid), 64'd0);
    end

    // Walking single request.
    for (int i = 0; i < 8; i++) begin
      if_r.req = 8'h01 << i;
      tick();
      check("rr_walk_idx", 64'(if_r.gnt_idx), 64'(i));
      check("rr_walk_onehot", 64'(if_r.gnt_onehot), 64'(8'h01 << i));
      if_r.ack = 1'b1;
      tick();
      if_r.ack = 1'b0;
    end

    // Wrap-around: after serving 0, N-1 is top priority.
    if_r.req = 8'h01;
    tick();
    check("rr_wrap0_idx", 64'(if_r.gnt_idx), 64'd0);
    if_r.ack = 1'b1;
    tick();
    if_r.ack = 1'b0;
    if_r.req = 8'hFF;
    tick();
    check("rr_wrap_idx", 64'(if_r.gnt_idx), 64'd7);
    check("rr_wrap_onehot", 64'(if_r.gnt_onehot), 64'h80);
    if_r.ack = 1'b1;
    tick();
    if_r.ack = 1'b0;

    // Pointer 7: 0x28 -> 5; then pointer 5: 0x88 -> 3 (fixed would pick 7).
    if_r.req = 8'h28;
    tick();
    check("rr_k7_idx", 64'(if_r.gnt_idx), 64'd5);
    if_r.ack = 1'b1;
    tick();
    if_r.ack = 1'b0;
    if_r.req = 8'h88;
    tick();
    check("rr_k5_idx", 64'(if_r.gnt_idx), 64'd3);
    check("rr_k5_onehot", 64'(if_r.gnt_onehot), 64'h08);

    // Requests drop mid-grant: grant held.
    if_r.req = 8'h00;
    tick();
    tick();
    check("rr_drop_valid", 64'(if_r.gnt_valid), 64'd1);
    check("rr_drop_idx", 64'(if_r.gnt_idx), 64'd3);

    // Reset mid-grant discards it and clears the pointer, even with ack high.
    rst = 1'b1;
    if_r.ack = 1'b1;
    tick();
    rst = 1'b0;
    if_r.ack = 1'b0;
    check("rr_rst_valid", 64'(if_r.gnt_valid), 64'd0);
    check("rr_rst_idx", 64'(if_r.gnt_idx), 64'd0);
    check("rr_rst_onehot", 64'(if_r.gnt_onehot), 64'd0);
    check("rr_rst_ptr", 64'(u_rr.rr_ptr_q), 64'd0);
    if_r.req = 8'h88;
    tick();
    check("rr_post_rst_idx", 64'(if_r.gnt_idx), 64'd7);

    // N=5 smoke.
    if_s.req = 5'b10000;
    tick();
    check("n5_valid", 64'(if_s.gnt_valid), 64'd1);
    check("n5_idx", 64'(if_s.gnt_idx), 64'd4);
    check("n5_onehot", 64'(if_s.gnt_onehot), 64'h10);
    if_s.ack = 1'b1;
    if_s.req = 5'b00110;
    tick();
    if_s.ack = 1'b0;
    check("n5_ack_valid", 64'(if_s.gnt_valid), 64'd0);
    tick();
    check("n5_idx2", 64'(if_s.gnt_idx), 64'd2);
    check("n5_onehot2", 64'(if_s.gnt_onehot), 64'h04);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_priority_arbiter.md
PARAM_PRIORITY_ARBITER -- requirements
Module: param_priority_arbiter

Interface
REQ-001 Parameter N: default 8; number of request lines; legal range 2..64.
REQ-002 Parameter RR_MODE: default 0; 0 = fixed priority, 1 = round-robin priority.
REQ-003 Derived constant W = clog2(N); this is the width of the grant index and is not user-settable.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req  input  N  request lines; bit i high = requester i pending.
REQ-007 ack  input  1  consumer accepts the current grant; meaningful only while gnt_valid=1.
REQ-008 gnt_valid  output  1  registered; grant outputs hold a valid grant.
REQ-009 gnt_idx  output  W  registered; binary index of the granted requester.
REQ-010 gnt_onehot  output  N  registered; one-hot form of gnt_idx, all-zero when gnt_valid=0.

Function
REQ-011 The FSM shall have exactly two states: IDLE and GRANT.
REQ-012 In IDLE with req != 0, the block shall select a winner, load gnt_idx and gnt_onehot, set gnt_valid=1 and enter GRANT on the next edge.
- Latency from req sampled to gnt_valid high: 1 cycle.
REQ-013 In IDLE with req == 0, the block shall remain in IDLE with gnt_valid=0; gnt_idx keeps its previous value.
REQ-014 Fixed mode: the winner shall be the highest set index, so N-1 has highest priority and 0 lowest.
REQ-015 Round-robin mode: with last-acknowledged index k, priority order shall be k-1, k-2, ..., 0, N-1, ..., k.
- The just-served requester becomes the lowest priority.
REQ-016 The round-robin pointer k shall update to gnt_idx only on a cycle where GRANT and ack are both high.
REQ-017 In GRANT, gnt_valid, gnt_idx and gnt_onehot shall hold stable until ack, even if req changes or the granted bit drops.
REQ-018 In GRANT with ack=1, the FSM shall return to IDLE on the next edge with gnt_valid=0.
- Back-to-back grants are therefore separated by exactly one idle cycle.
REQ-019 ack in IDLE shall be ignored and shall not affect state or the pointer.
REQ-020 Pointer wrap-around: after an ack of index 0, the highest priority shall be N-1.
REQ-021 If N is not a power of two, gnt_idx shall never take a value >= N.

Reset
REQ-022 While rst=1 at a clock edge, the block shall reset on that edge to:
- state = IDLE
- gnt_valid = 0
- gnt_idx = 0
- gnt_onehot = 0
- round-robin pointer k = 0
REQ-023 Reset shall take precedence over req and ack on the same edge, including mid-GRANT; the outstanding grant is discarded and not acknowledged.
REQ-024 With k=0 after reset, round-robin priority order shall equal fixed-mode order.

Structure
REQ-025 State encoding (IDLE, GRANT) and a clog2 helper function shall live in a shared package, arb_pkg.
REQ-026 Winner selection shall be one combinational sub-module, prio_select, with inputs req, k and RR_MODE and outputs winner index and any-request flag.
- The FSM and output registers stay in param_priority_arbiter.

Verification
REQ-027 The bench shall run at N=8, once with RR_MODE=0 and once with RR_MODE=1, plus a smoke run at N=5.
REQ-028 Scenario: reset then req=8'h00 for 5 cycles -> gnt_valid=0 throughout, gnt_onehot=0.
REQ-029 Scenario: fixed mode, req=8'b0010_0110 -> one cycle later gnt_valid=1, gnt_idx=5, gnt_onehot=8'h20; held for 3 cycles without ack; ack -> gnt_valid=0 next cycle.
REQ-030 Scenario: round-robin, req held at 8'h81 with ack each grant -> grants in order 7, 0, 7, 0, with one idle cycle between grants.
REQ-031 Scenario: round-robin, walking single bit 8'h01 << i for i=0..7 with ack -> gnt_idx equals i each time.
- Then req=8'hFF after acking index 0 -> gnt_idx=7 (wrap-around).
REQ-032 Scenario: in GRANT with gnt_idx=3, req drops to 0 -> grant held.
- Then assert rst -> next cycle gnt_valid=0, gnt_idx=0, pointer=0.
REQ-033 Scenario: N=5, req=5'b10000 -> gnt_idx=4, gnt_onehot=5'b10000.
